// File: rtl/lat_tracker_pkg.sv
// rtl/lat_tracker_pkg.sv - shared types, default sizes and saturating add for lat_tracker
// Ports: none (package).
package lat_tracker_pkg;

  localparam int DEF_DEPTH = 16;
  localparam int DEF_TS_W  = 32;
  localparam int DEF_CNT_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Unsigned add clamped to the largest w-bit value; operands are
  // zero-extended into 64 bits so any width up to 64 can share it.
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input int unsigned w);
    logic [64:0] sum;
    logic [63:0] lim;
    lim = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, lim}) return lim;
    return sum[63:0];
  endfunction

endpackage

// File: rtl/lat_tracker_if.sv
// rtl/lat_tracker_if.sv - issue/complete strobe bundle observed by lat_tracker
// Signals: start_valid (transaction issued this cycle), done_valid (transaction completed this cycle).
// Modports: master drives the strobes, slave observes them.
interface lat_tracker_if;
  logic start_valid;
  logic done_valid;

  modport master (output start_valid, output done_valid);
  modport slave  (input  start_valid, input  done_valid);
endinterface

// File: rtl/lat_ts_fifo.sv
// rtl/lat_ts_fifo.sv - DEPTH x W in-order timestamp buffer
// Ports: clk, rst (async active-low), push/push_data, pop/pop_data (head, valid when !empty),
//        full, empty, count (entries held).
module lat_ts_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  // The extra MSB on each pointer tells full (same index, different lap)
  // apart from empty (same index, same lap).
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count    = wr_ptr - rd_ptr;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/lat_tracker.sv
// rtl/lat_tracker.sv - timestamps issues, pairs completions in order, accumulates latency
// Ports: clk, rst (async active-low), evt (start_valid/done_valid strobes), trans_num (expected count),
//        lat_total (saturating sum), lat_max, lat_min, done_cnt, in_flight, finish, err_ovf, err_udf.
module lat_tracker
  import lat_tracker_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int TS_W  = DEF_TS_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  lat_tracker_if.slave           evt,
  input  logic [CNT_W-1:0]       trans_num,
  output logic [CNT_W-1:0]       lat_total,
  output logic [TS_W-1:0]        lat_max,
  output logic [TS_W-1:0]        lat_min,
  output logic [CNT_W-1:0]       done_cnt,
  output logic [$clog2(DEPTH):0] in_flight,
  output logic                   finish,
  output logic                   err_ovf,
  output logic                   err_udf
);

  state_t state, state_nxt;

  logic [TS_W-1:0]  ts;
  logic [TS_W-1:0]  head;
  logic [TS_W-1:0]  lat;
  logic [CNT_W-1:0] done_inc;
  logic             full, empty;
  logic             bypass, do_push, do_pop, accept, ovf, udf;

  lat_ts_fifo #(.DEPTH(DEPTH), .W(TS_W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (do_push),
    .push_data (ts),
    .pop       (do_pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (in_flight)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    bypass    = 1'b0;
    do_push   = 1'b0;
    do_pop    = 1'b0;
    accept    = 1'b0;
    ovf       = 1'b0;
    udf       = 1'b0;
    done_inc  = done_cnt + CNT_W'(1);
    unique case (state)
      IDLE, RUN: begin
        if (state == IDLE && trans_num == '0) begin
          state_nxt = DONE;
        end else begin
          // Empty buffer with a same-cycle start: pair them directly.
          bypass  = evt.start_valid && evt.done_valid && empty;
          do_pop  = evt.done_valid && !empty;
          // A full buffer still accepts a start when the head leaves this cycle.
          do_push = evt.start_valid && !bypass && (!full || do_pop);
          ovf     = evt.start_valid && full && !evt.done_valid;
          udf     = evt.done_valid && empty && !evt.start_valid;
          accept  = bypass || do_pop;
          if (state == IDLE && evt.start_valid) state_nxt = RUN;
          if (accept && done_inc == trans_num)  state_nxt = DONE;
        end
      end
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Modulo subtraction absorbs a single wrap of the timestamp counter.
  assign lat = bypass ? '0 : (ts - head);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts        <= '0;
      lat_total <= '0;
      lat_max   <= '0;
      lat_min   <= '1;
      done_cnt  <= '0;
      finish    <= 1'b0;
      err_ovf   <= 1'b0;
      err_udf   <= 1'b0;
    end else begin
      ts <= ts + TS_W'(1);
      if (ovf) err_ovf <= 1'b1;
      if (udf) err_udf <= 1'b1;
      if (accept) begin
        done_cnt  <= done_inc;
        lat_total <= CNT_W'(sat_add(64'(lat_total), 64'(lat), CNT_W));
        if (lat > lat_max) lat_max <= lat;
        if (lat < lat_min) lat_min <= lat;
      end
      // finish rises on the same edge as the last total update.
      if (state != DONE && state_nxt == DONE) finish <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lat_tracker.sv
// tb/tb_lat_tracker.sv - directed self-checking bench for lat_tracker (DEPTH=4, TS_W=8, CNT_W=8)
module tb_lat_tracker;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] trans_num = 8'd0;
  logic [7:0] lat_total, lat_max, lat_min, done_cnt;
  logic [2:0] in_flight;
  logic       finish, err_ovf, err_udf;
  logic [7:0] tb_ts;
  int         checks = 0;
  int         errors = 0;

  lat_tracker_if evt ();

  lat_tracker #(.DEPTH(4), .TS_W(8), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .evt       (evt),
    .trans_num (trans_num),
    .lat_total (lat_total),
    .lat_max   (lat_max),
    .lat_min   (lat_min),
    .done_cnt  (done_cnt),
    .in_flight (in_flight),
    .finish    (finish),
    .err_ovf   (err_ovf),
    .err_udf   (err_udf)
  );

  always #5 clk = ~clk;

  // Reference cycle count: 0 on the first edge after release, +1 per edge.
  always @(posedge clk or negedge rst) begin
    if (!rst) tb_ts <= 8'd0;
    else      tb_ts <= tb_ts + 8'd1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset(input logic [7:0] tn);
    @(negedge clk);
    rst = 1'b0;
    trans_num = tn;
    evt.start_valid = 1'b0;
    evt.done_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Drive the strobes so the DUT samples them on the edge where its ts equals k.
  task automatic at_ts(input logic [7:0] k, input logic s, input logic d);
    int n = 0;
    while (tb_ts != k && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (tb_ts != k) begin
      checks++;
      errors++;
      $display("FAIL at_ts timeout: ts %0d expected %0d", tb_ts, k);
    end else begin
      evt.start_valid = s;
      evt.done_valid = d;
      @(negedge clk);
      evt.start_valid = 1'b0;
      evt.done_valid = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    evt.start_valid = 1'b0;
    evt.done_valid = 1'b0;

    // Reset values
    @(negedge clk);
    check("rst lat_total", lat_total, 0);
    check("rst lat_max", lat_max, 0);
    check("rst lat_min", lat_min, 8'hFF);
    check("rst done_cnt", done_cnt, 0);
    check("rst in_flight", in_flight, 0);
    check("rst finish", finish, 0);
    check("rst err_ovf", err_ovf, 0);
    check("rst err_udf", err_udf, 0);

    // Single transaction: start 5, done 12
    do_reset(8'd1);
    at_ts(8'd5, 1'b1, 1'b0);
    check("single in_flight mid", in_flight, 1);
    check("single finish mid", finish, 0);
    at_ts(8'd12, 1'b0, 1'b1);
    check("single lat_total", lat_total, 7);
    check("single lat_min", lat_min, 7);
    check("single lat_max", lat_max, 7);
    check("single finish", finish, 1);
    check("single in_flight", in_flight, 0);
    check("single done_cnt", done_cnt, 1);

    // Pipelined: starts 2,3,4 dones 10,11,15 -> 8+8+11
    do_reset(8'd3);
    at_ts(8'd2, 1'b1, 1'b0);
    at_ts(8'd3, 1'b1, 1'b0);
    at_ts(8'd4, 1'b1, 1'b0);
    check("pipe in_flight 3", in_flight, 3);
    at_ts(8'd10, 1'b0, 1'b1);
    at_ts(8'd11, 1'b0, 1'b1);
    check("pipe done_cnt 2", done_cnt, 2);
    check("pipe finish early", finish, 0);
    check("pipe lat_total 2", lat_total, 16);
    at_ts(8'd15, 1'b0, 1'b1);
    check("pipe lat_total", lat_total, 27);
    check("pipe lat_max", lat_max, 11);
    check("pipe lat_min", lat_min, 8);
    check("pipe finish", finish, 1);
    check("pipe in_flight", in_flight, 0);

    // Same-cycle start and done with empty buffer
    do_reset(8'd1);
    at_ts(8'd9, 1'b1, 1'b1);
    check("bypass lat_total", lat_total, 0);
    check("bypass lat_min", lat_min, 0);
    check("bypass finish", finish, 1);
    check("bypass err_udf", err_udf, 0);
    check("bypass in_flight", in_flight, 0);

    // Overflow, then push+pop on a full buffer
    do_reset(8'd10);
    for (int i = 1; i <= 4; i++) at_ts(8'(i), 1'b1, 1'b0);
    check("ovf before", err_ovf, 0);
    check("ovf in_flight full", in_flight, 4);
    at_ts(8'd5, 1'b1, 1'b0);
    check("ovf err_ovf", err_ovf, 1);
    check("ovf in_flight", in_flight, 4);
    at_ts(8'd6, 1'b1, 1'b1);
    check("full pushpop in_flight", in_flight, 4);
    check("full pushpop lat_total", lat_total, 5);
    check("full pushpop done_cnt", done_cnt, 1);

    // Underflow after reset
    do_reset(8'd1);
    at_ts(8'd3, 1'b0, 1'b1);
    check("udf err_udf", err_udf, 1);
    check("udf done_cnt", done_cnt, 0);
    check("udf lat_total", lat_total, 0);
    check("udf finish", finish, 0);

    // Timestamp wrap: start 250, done 4 -> 10
    do_reset(8'd1);
    at_ts(8'd250, 1'b1, 1'b0);
    at_ts(8'd4, 1'b0, 1'b1);
    check("wrap lat_total", lat_total, 10);
    check("wrap lat_max", lat_max, 10);
    check("wrap finish", finish, 1);

    // Saturation: two latencies of 200
    do_reset(8'd2);
    at_ts(8'd1, 1'b1, 1'b0);
    at_ts(8'd2, 1'b1, 1'b0);
    at_ts(8'd201, 1'b0, 1'b1);
    check("sat lat_total first", lat_total, 200);
    at_ts(8'd202, 1'b0, 1'b1);
    check("sat lat_total", lat_total, 255);
    check("sat lat_max", lat_max, 200);
    check("sat lat_min", lat_min, 200);
    check("sat finish", finish, 1);

    // Asynchronous reset mid-run with a full buffer
    do_reset(8'd5);
    at_ts(8'd1, 1'b1, 1'b0);
    at_ts(8'd2, 1'b1, 1'b0);
    at_ts(8'd3, 1'b1, 1'b0);
    at_ts(8'd5, 1'b0, 1'b1);
    at_ts(8'd6, 1'b1, 1'b0);
    at_ts(8'd7, 1'b1, 1'b0);
    at_ts(8'd8, 1'b1, 1'b0);
    check("mid in_flight", in_flight, 4);
    check("mid lat_total", lat_total, 4);
    check("mid err_ovf", err_ovf, 1);
    #1;
    rst = 1'b0;
    #1;
    check("async lat_total", lat_total, 0);
    check("async lat_max", lat_max, 0);
    check("async lat_min", lat_min, 8'hFF);
    check("async done_cnt", done_cnt, 0);
    check("async in_flight", in_flight, 0);
    check("async err_ovf", err_ovf, 0);
    check("async finish", finish, 0);
    @(negedge clk);
    trans_num = 8'd1;
    rst = 1'b1;
    at_ts(8'd2, 1'b0, 1'b1);
    check("post rst err_udf", err_udf, 1);
    check("post rst done_cnt", done_cnt, 0);

    // trans_num = 0 finishes immediately and then ignores strobes
    do_reset(8'd0);
    check("tn0 finish at release", finish, 0);
    @(negedge clk);
    check("tn0 finish", finish, 1);
    check("tn0 lat_total", lat_total, 0);
    at_ts(8'd3, 1'b1, 1'b1);
    at_ts(8'd4, 1'b0, 1'b1);
    at_ts(8'd5, 1'b1, 1'b0);
    check("tn0 done_cnt", done_cnt, 0);
    check("tn0 in_flight", in_flight, 0);
    check("tn0 err_udf", err_udf, 0);
    check("tn0 finish hold", finish, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
